// File: rtl/alu_pipe.sv
// Pipelined, handshaked ALU with registered result/flags and an iterative shift-add multiplier.
// One op in flight at a time; results hold until the consumer takes them.
module alu_pipe #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic [1:0]       dbg_state
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] LP_WIDTH = WIDTH'(WIDTH);

    localparam logic [2:0] OP_XOR = 3'b000;
    localparam logic [2:0] OP_AND = 3'b001;
    localparam logic [2:0] OP_OR  = 3'b010;
    localparam logic [2:0] OP_ADD = 3'b011;
    localparam logic [2:0] OP_SUB = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_SHR = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Handshake: a transfer happens on a rising edge where valid && ready on that side;
    // out_valid/result/flags hold stable from assertion until consumed.

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_result;
    logic                 r_z, r_n, r_c, r_v;
    logic [2*WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]     r_mplier;
    logic [2*WIDTH-1:0]   r_acc;
    logic [CNT_W-1:0]     r_cnt;

    logic                 w_accept;
    logic                 w_mul_last;
    logic [WIDTH:0]       w_add;
    logic [WIDTH:0]       w_sub;
    logic                 w_shift_big;
    logic [WIDTH-1:0]     w_alu_res;
    logic                 w_alu_c;
    logic                 w_alu_v;

    assign in_ready   = rst_n && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign out_valid  = (r_state == S_DONE);
    assign w_accept   = in_valid && in_ready;
    assign w_mul_last = (r_cnt == CNT_W'(WIDTH));
    assign result     = r_result;
    assign flag_z     = r_z;
    assign flag_n     = r_n;
    assign flag_c     = r_c;
    assign flag_v     = r_v;
    assign dbg_state  = r_state;

    assign w_add       = {1'b0, a} + {1'b0, b};
    assign w_sub       = {1'b0, a} - {1'b0, b};
    assign w_shift_big = (b >= LP_WIDTH);

    always_comb begin
        w_alu_res = '0;
        w_alu_c   = 1'b0;
        w_alu_v   = 1'b0;
        case (op)
            OP_XOR: w_alu_res = a ^ b;
            OP_AND: w_alu_res = a & b;
            OP_OR:  w_alu_res = a | b;
            OP_ADD: begin
                w_alu_res = w_add[WIDTH-1:0];
                w_alu_c   = w_add[WIDTH];
                w_alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (w_add[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the zero-extended difference is the borrow (a < b unsigned).
                w_alu_res = w_sub[WIDTH-1:0];
                w_alu_c   = w_sub[WIDTH];
                w_alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (w_sub[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: w_alu_res = w_shift_big ? '0 : (a << b);
            OP_SHR: w_alu_res = w_shift_big ? '0 : (a >> b);
            default: w_alu_res = '0;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_next_state = (op == OP_MUL) ? S_MUL : S_DONE;
            end
            S_MUL: begin
                if (w_mul_last) w_next_state = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    if (w_accept) w_next_state = (op == OP_MUL) ? S_MUL : S_DONE;
                    else          w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_z      <= 1'b0;
            r_n      <= 1'b0;
            r_c      <= 1'b0;
            r_v      <= 1'b0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept && (op == OP_MUL)) begin
            r_mcand  <= {{WIDTH{1'b0}}, a};
            r_mplier <= b;
            r_acc    <= '0;
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_result <= w_alu_res;
            r_z      <= (w_alu_res == '0);
            r_n      <= w_alu_res[WIDTH-1];
            r_c      <= w_alu_c;
            r_v      <= w_alu_v;
        end else if (r_state == S_MUL) begin
            // WIDTH shift-add steps, then one extra cycle to register result and flags.
            if (w_mul_last) begin
                r_result <= r_acc[WIDTH-1:0];
                r_z      <= (r_acc[WIDTH-1:0] == '0);
                r_n      <= r_acc[WIDTH-1];
                r_c      <= |r_acc[2*WIDTH-1:WIDTH];
                r_v      <= 1'b0;
            end else begin
                if (r_mplier[0]) r_acc <= r_acc + r_mcand;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (WIDTH=8): arithmetic/flag vectors, multiply latency,
// backpressure, back-to-back throughput and reset during a multiply.
module tb_alu_pipe;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_z, flag_n, flag_c, flag_v;
    logic [1:0]   dbg_state;

    int checks = 0;
    int errors = 0;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] t_op, input logic [W-1:0] t_a, input logic [W-1:0] t_b);
        in_valid = 1'b1;
        op       = t_op;
        a        = t_a;
        b        = t_b;
    endtask

    // f = {Z, N, C, V}
    task automatic check_out(input string tag, input logic [W-1:0] res, input logic [3:0] f);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_res"},   32'(result),    32'(res));
        check({tag, "_flags"}, 32'({flag_z, flag_n, flag_c, flag_v}), 32'(f));
    endtask

    task automatic do_op(input string tag, input logic [2:0] t_op, input logic [W-1:0] t_a,
                         input logic [W-1:0] t_b, input logic [W-1:0] res, input logic [3:0] f);
        drive(t_op, t_a, t_b);
        step();
        in_valid = 1'b0;
        check_out(tag, res, f);
        step();
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    task automatic do_mul(input string tag, input logic [W-1:0] t_a, input logic [W-1:0] t_b,
                          input logic [W-1:0] res, input logic [3:0] f);
        drive(3'b111, t_a, t_b);
        step();
        // Garbage on the inputs while busy must be neither sampled nor queued.
        drive(3'b011, 8'h01, 8'h01);
        for (int k = 1; k <= W + 1; k++) begin
            if (k == W) in_valid = 1'b0;
            step();
            if (k <= W) begin
                check($sformatf("%s_busy_valid%0d", tag, k), 32'(out_valid), 32'd0);
                check($sformatf("%s_busy_ready%0d", tag, k), 32'(in_ready), 32'd0);
            end
        end
        check_out(tag, res, f);
        step();
        check({tag, "_drop"}, 32'(out_valid), 32'd0);
    endtask

    logic [2:0]   bb_op  [6] = '{3'b001, 3'b010, 3'b101, 3'b110, 3'b101, 3'b110};
    logic [W-1:0] bb_a   [6] = '{8'hF0, 8'h81, 8'h81, 8'h81, 8'h81, 8'h80};
    logic [W-1:0] bb_b   [6] = '{8'h3C, 8'h04, 8'h01, 8'h09, 8'h08, 8'h07};
    logic [W-1:0] bb_res [6] = '{8'h30, 8'h85, 8'h02, 8'h00, 8'h00, 8'h01};
    logic [3:0]   bb_f   [6] = '{4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b1000, 4'b0000};

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        a         = '0;
        b         = '0;
        out_ready = 1'b1;

        step();
        step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_res",   32'(result), 32'd0);
        check("rst_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        rst_n = 1'b1;
        #1;
        check("idle_ready", 32'(in_ready), 32'd1);
        check("idle_state", 32'(dbg_state), 32'd0);

        do_op("add_ff_01", 3'b011, 8'hFF, 8'h01, 8'h00, 4'b1010);
        do_op("sub_80_01", 3'b100, 8'h80, 8'h01, 8'h7F, 4'b0001);
        do_op("sub_01_02", 3'b100, 8'h01, 8'h02, 8'hFF, 4'b0110);

        do_mul("mul_0d_0b", 8'h0D, 8'h0B, 8'h8F, 4'b0100);
        do_mul("mul_10_10", 8'h10, 8'h10, 8'h00, 4'b1010);

        // Backpressure: XOR result held while a new op waits.
        out_ready = 1'b0;
        drive(3'b000, 8'hF0, 8'hFF);
        step();
        drive(3'b010, 8'h0F, 8'h30);
        for (int k = 0; k < 3; k++) begin
            check_out($sformatf("bp_hold%0d", k), 8'h0F, 4'b0000);
            check($sformatf("bp_ready%0d", k), 32'(in_ready), 32'd0);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_up", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check_out("bp_next", 8'h3F, 4'b0000);
        step();
        check("bp_drop", 32'(out_valid), 32'd0);

        // Back-to-back with out_ready held high: one result per cycle, in order.
        drive(bb_op[0], bb_a[0], bb_b[0]);
        step();
        for (int i = 0; i < 6; i++) begin
            if (i < 5) drive(bb_op[i+1], bb_a[i+1], bb_b[i+1]);
            else       in_valid = 1'b0;
            check_out($sformatf("b2b%0d", i), bb_res[i], bb_f[i]);
            step();
        end
        check("b2b_drop", 32'(out_valid), 32'd0);

        // Reset during a multiply discards it.
        drive(3'b111, 8'h0D, 8'h0B);
        step();
        in_valid = 1'b0;
        repeat (4) step();
        check("mr_state_mul", 32'(dbg_state), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(out_valid), 32'd0);
        check("mr_res",   32'(result), 32'd0);
        check("mr_flags", 32'({flag_z, flag_n, flag_c, flag_v}), 32'd0);
        check("mr_ready", 32'(in_ready), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("mr_idle_ready", 32'(in_ready), 32'd1);
        check("mr_idle_state", 32'(dbg_state), 32'd0);
        for (int k = 0; k < 12; k++) begin
            step();
            check($sformatf("mr_no_stale%0d", k), 32'(out_valid), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
